// File: rtl/addsub_seq_cska_pkg.sv
// Shared types and elaboration helpers for the block-serial carry-skip
// adder/subtractor (addsub_seq_cska).
package addsub_seq_cska_pkg;

  // Controller states: accept operands, walk the groups, present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of BLK-bit carry-skip groups in a WIDTH-bit operand.
  function automatic int nblocks(input int width, input int blk);
    return width / blk;
  endfunction

  // Width of the group index counter; never narrower than one bit.
  function automatic int idx_width(input int width, input int blk);
    int nb;
    nb = width / blk;
    if (nb > 1) begin
      return $clog2(nb);
    end else begin
      return 1;
    end
  endfunction

  // Index width for the default 32-bit / 8-bit-group configuration.
  localparam int IDX_W_DEFAULT = idx_width(32, 8);

endpackage

// File: rtl/addsub_seq_cska_if.sv
// Operand/result handshake bundle for addsub_seq_cska.
// master = operand producer / result consumer, slave = the adder.
interface addsub_seq_cska_if #(
  parameter int WIDTH     = 32,
  parameter int EXT_WIDTH = 67
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 sub;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     sum;
  logic [EXT_WIDTH-1:0] sum_ext;
  logic                 cout;
  logic                 ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, sum_ext, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, sum_ext, cout, ovf
  );
endinterface

// File: rtl/addsub_seq_cska_cska_block.sv
// One BLK-bit carry-skip group: ripple sum plus a skip mux on the carry.
// Purely combinational; the sequencer reuses a single instance per cycle.
module cska_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a_slice,
  input  logic [BLK-1:0] b_slice,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           p
);
  logic w_rip_cout;

  // Bit-by-bit ripple through the group.
  always_comb begin
    logic c;
    c = cin;
    s = {BLK{1'b0}};
    for (int i = 0; i < BLK; i++) begin
      s[i] = a_slice[i] ^ b_slice[i] ^ c;
      c    = (a_slice[i] & b_slice[i]) | ((a_slice[i] ^ b_slice[i]) & c);
    end
    w_rip_cout = c;
  end

  // XOR propagate: every bit passes the incoming carry straight through.
  assign p    = &(a_slice ^ b_slice);
  // Skip path bypasses the ripple chain when the whole group propagates.
  assign cout = p ? cin : w_rip_cout;

endmodule

// File: rtl/addsub_seq_cska.sv
// addsub_seq_cska: WIDTH-generic adder/subtractor that evaluates one
// BLK-bit carry-skip group per clock, with valid/ready handshakes on both
// sides and a sign-extended result plus carry and signed-overflow flags.
// Optional build macro: ADDSUB_SAT_EN -- saturate sum on signed overflow.
module addsub_seq_cska
  import addsub_seq_cska_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BLK       = 8,
  parameter int EXT_WIDTH = 67
) (
  input logic              clk,
  input logic              rst_n,
  addsub_seq_cska_if.slave bus
);
  localparam int NB    = nblocks(WIDTH, BLK);
  localparam int IDX_W = idx_width(WIDTH, BLK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  if ((BLK < 1) || (BLK > WIDTH) || ((WIDTH % BLK) != 0) || (EXT_WIDTH < WIDTH)) begin : g_bad_cfg
    $error("addsub_seq_cska: WIDTH must be a multiple of BLK and EXT_WIDTH >= WIDTH");
  end

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 w_in_ready_nxt;
  logic                 w_out_valid_nxt;
  logic                 w_accept;
  logic                 w_last;

  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_res;
  logic                 r_carry;
  logic [IDX_W-1:0]     r_idx;

  logic [WIDTH-1:0]     r_sum;
  logic [EXT_WIDTH-1:0] r_sum_ext;
  logic                 r_cout;
  logic                 r_ovf;

  logic [BLK-1:0]       w_a_slice;
  logic [BLK-1:0]       w_b_slice;
  logic [BLK-1:0]       w_s;
  logic                 w_gcout;
  logic                 w_gp;
  logic                 w_c_msb;
  logic                 w_ovf;
  logic [WIDTH-1:0]     w_full;
  logic [WIDTH-1:0]     w_final;

  // Current group of the latched operands (b already conditionally inverted).
  assign w_a_slice = r_a[int'(r_idx)*BLK +: BLK];
  assign w_b_slice = r_b[int'(r_idx)*BLK +: BLK];

  cska_block #(.BLK(BLK)) u_cska (
    .a_slice (w_a_slice),
    .b_slice (w_b_slice),
    .cin     (r_carry),
    .s       (w_s),
    .cout    (w_gcout),
    .p       (w_gp)
  );

  // Carry into the MSB is recovered from the top sum bit; only meaningful
  // on the last group, which is the only time ovf is captured.
  assign w_c_msb = w_s[BLK-1] ^ w_a_slice[BLK-1] ^ w_b_slice[BLK-1];
  assign w_ovf   = w_c_msb ^ w_gcout;

  // Merge this cycle's group sum into the partial result.
  always_comb begin
    w_full = r_res;
    w_full[int'(r_idx)*BLK +: BLK] = w_s;
  end

  // Final sum: wrapped, or clamped toward the true sign on overflow.
  always_comb begin
    w_final = w_full;
`ifdef ADDSUB_SAT_EN
    if (w_ovf) begin
      // Wrapped MSB set means the true result was positive, so clamp to max.
      w_final            = {WIDTH{w_full[WIDTH-1]}};
      w_final[WIDTH-1]   = ~w_full[WIDTH-1];
    end else begin
      w_final = w_full;
    end
`else
    w_final = w_full;
`endif
  end

  // Next-state and next handshake-flag decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_accept        = 1'b0;
    w_last          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_accept        = 1'b1;
          w_state_nxt     = ST_BUSY;
          w_in_ready_nxt  = 1'b0;
          w_out_valid_nxt = 1'b0;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_in_ready_nxt  = 1'b1;
          w_out_valid_nxt = 1'b0;
        end
      end
      ST_BUSY: begin
        if (r_idx == LAST_IDX) begin
          w_last          = 1'b1;
          w_state_nxt     = ST_DONE;
          w_out_valid_nxt = 1'b1;
        end else begin
          w_state_nxt     = ST_BUSY;
        end
      end
      ST_DONE: begin
        // Ready is raised only on the following cycle, so a consume and a
        // new accept never share an edge.
        if (bus.out_ready) begin
          w_state_nxt     = ST_IDLE;
          w_in_ready_nxt  = 1'b1;
          w_out_valid_nxt = 1'b0;
        end else begin
          w_state_nxt     = ST_DONE;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State register and registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Operand latch, per-group carry/index walk and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= {WIDTH{1'b0}};
      r_b       <= {WIDTH{1'b0}};
      r_res     <= {WIDTH{1'b0}};
      r_carry   <= 1'b0;
      r_idx     <= {IDX_W{1'b0}};
      r_sum     <= {WIDTH{1'b0}};
      r_sum_ext <= {EXT_WIDTH{1'b0}};
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b ^ {WIDTH{bus.sub}};
      r_carry <= bus.sub;
      r_idx   <= {IDX_W{1'b0}};
    end else if (r_state == ST_BUSY) begin
      r_res   <= w_full;
      r_carry <= w_gcout;
      if (w_last) begin
        r_idx     <= {IDX_W{1'b0}};
        r_sum     <= w_final;
        r_sum_ext <= EXT_WIDTH'($signed(w_final));
        r_cout    <= w_gcout;
        r_ovf     <= w_ovf;
      end else begin
        r_idx     <= r_idx + IDX_W'(1);
      end
    end else begin
      r_carry <= r_carry;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.sum_ext   = r_sum_ext;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: doc/addsub_seq_cska.md
# addsub_seq_cska

Block-serial, parametrised adder/subtractor for the integer arithmetic datapath. It supersedes the fixed 32/33/34-bit carry-skip adders with a single WIDTH-generic unit that processes one BLK-bit carry-skip group per clock. Operands are accepted and results returned over valid/ready handshakes. It serves the add, divide and multiply sequencers, which instantiate it at their own widths, and it produces a sign-extended result plus carry and overflow flags.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of BLK.
- BLK, 8: carry-skip group width, i.e. bits processed per BUSY cycle; 1 ≤ BLK ≤ WIDTH.
- EXT_WIDTH, 67: width of the sign-extended result; must be ≥ WIDTH.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A (two's complement).
- b  in  WIDTH  operand B (two's complement).
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- sum_ext  out  EXT_WIDTH  sum sign-extended from bit WIDTH−1.
- cout  out  1  carry out of the MSB (for subtraction: 1 means no borrow).
- ovf  out  1  signed overflow.

## Operation
- State machine: IDLE → BUSY → DONE → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a and b^{WIDTH{sub}};
  - carry register = sub;
  - block index idx = 0;
  - go to BUSY.
- BUSY: each cycle computes group idx through cska_block:
  - group sum = ripple of the latched A/B slice plus the carry register;
  - group propagate P = &(a_slice ^ b_slice) (XOR propagate, not OR);
  - group carry-out = P ? carry_in : ripple_cout (skip path).
  - The group sum is written into the result register, the carry register takes the group carry-out, and idx increments.
  - When idx = NB−1 (NB = WIDTH/BLK): capture cout and ovf, then go to DONE.
- ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- DONE: out_valid=1. sum, sum_ext, cout and ovf are held stable until out_valid&&out_ready, then return to IDLE.
- in_ready=0 in BUSY and DONE. No new operand is accepted in the same cycle a result is consumed.
- Changes on a, b or sub outside the accepting cycle have no effect.
- Reset (rst_n=0 at a clock edge), in any state including mid-BUSY:
  - state = IDLE, the in-flight operation is discarded;
  - out_valid = 0, in_ready = 1 from the first cycle after reset;
  - sum = 0, sum_ext = 0, cout = 0, ovf = 0;
  - idx = 0, carry register = 0.

## Timing
- Acceptance at clock edge T. BUSY occupies edges T+1 … T+NB. out_valid is high from edge T+NB (the DONE state).
- Latency from acceptance to out_valid is NB cycles.
- Minimum issue interval is NB+2 cycles (BUSY, DONE, IDLE).
- BLK = WIDTH gives NB = 1: a single BUSY cycle.
- Combinational depth per cycle is one BLK-bit ripple plus one skip mux. There are no combinational paths from inputs to outputs.

## Configuration
- ADDSUB_SAT_EN defined: when ovf=1, sum saturates to signed max (0 followed by ones) if the true result is positive, or signed min (1 followed by zeros) if negative. sum_ext is derived from the saturated sum. ovf still reports 1.
- ADDSUB_SAT_EN undefined: sum wraps modulo 2^WIDTH. ovf is reported and no saturation logic is built.

## Structure
- addsub_pkg:
  - state enum (IDLE, BUSY, DONE);
  - function nblocks(WIDTH, BLK);
  - localparam for the idx width ($clog2 of NB, minimum 1).
- Sub-module cska_block (parameter BLK): inputs a_slice, b_slice, cin; outputs s, cout, p. Purely combinational; one instance, reused across cycles.
- Elaboration-time check fails if WIDTH % BLK ≠ 0 or EXT_WIDTH < WIDTH.

## Test plan
- WIDTH=32, BLK=8: a=578, b=678, sub=0 → sum=0x000004E8, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
- a=10, b=15, sub=1 → sum=0xFFFFFFFB, sum_ext = all ones above bit 2 (67-bit −5), cout=0, ovf=0.
- a=0xFFFFFFFF, b=1, sub=0 (full skip chain) → sum=0, cout=1, ovf=0. Also a=0x7FFFFFFF, b=1 → ovf=1; sum=0x80000000 without the macro, 0x7FFFFFFF with ADDSUB_SAT_EN.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs unchanged, in_ready=0, asserted in_valid ignored. Release → next cycle IDLE, in_ready=1.
- Drive rst_n=0 during the 2nd BUSY cycle → next cycle out_valid=0, in_ready=1, sum=0. A following 3+4 completes correctly with sum=7.
- WIDTH=33, BLK=11 and WIDTH=34, BLK=34: random signed add/sub vs. reference model → sum, cout and ovf match. Latency is 3 cycles and 1 cycle respectively.
